// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding, data width and parity helper.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

   // Expected parity bit: even parity by default, inverted for odd parity.
   function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversampling tick divider; the counter restarts on clear so ticks are phase-locked to the start edge.
module uart_rx_tick_gen #(
   parameter int CLK_RATE   = 100_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);
   localparam int DIV = CLK_RATE / (BAUD_RATE * OVERSAMPLE);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || clear)
         r_cnt <= '0;
      else if (r_cnt == LAST)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + 1'b1;
   end

   assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit validation at mid-bit, 8 data bits LSB first, stop check, valid/ready output.
// Optional parity bit compiled in with `define UART_RX_PARITY_EN.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_RATE   = 100_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rx_in,
   output logic [UART_DATA_BITS-1:0] rx_data,
   output logic                      rx_valid,
   input  logic                      rx_ready,
   output logic                      frame_err,
   output logic                      parity_err,
   output logic                      rx_overrun
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);

   rx_state_t r_state, w_next;
   logic r_sync1, r_sync2, r_prev;
   logic [TW-1:0] r_tcnt;
   logic [2:0] r_bit_idx;
   logic [UART_DATA_BITS-1:0] r_shift, r_data;
   logic r_valid, r_frame_err, r_overrun;
   logic w_tick, w_fall, w_half_done, w_bit_done;
   logic w_start_edge, w_data_smp, w_stop_smp, w_complete;

   uart_rx_tick_gen #(
      .CLK_RATE   (CLK_RATE),
      .BAUD_RATE  (BAUD_RATE),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (w_start_edge),
      .tick  (w_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= rx_in;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_fall      = r_prev & ~r_sync2;
   assign w_half_done = w_tick && (r_state == RX_START) && (r_tcnt == HALF_LAST);
   assign w_bit_done  = w_tick && (r_tcnt == BIT_LAST);

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= RX_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         RX_IDLE:  if (w_fall) w_next = RX_START;
         RX_START: if (w_half_done) w_next = r_sync2 ? RX_IDLE : RX_DATA;
`ifdef UART_RX_PARITY_EN
         RX_DATA:   if (w_bit_done && r_bit_idx == 3'd7) w_next = RX_PARITY;
         RX_PARITY: if (w_bit_done) w_next = RX_STOP;
`else
         RX_DATA:   if (w_bit_done && r_bit_idx == 3'd7) w_next = RX_STOP;
`endif
         RX_STOP:  if (w_bit_done) w_next = RX_IDLE;
         default:  w_next = RX_IDLE;
      endcase
   end

`ifdef UART_RX_PARITY_EN
   logic w_par_smp;
`endif

   always_comb begin
      w_start_edge = 1'b0;
      w_data_smp   = 1'b0;
      w_stop_smp   = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_smp    = 1'b0;
`endif
      case (r_state)
         RX_IDLE:   w_start_edge = w_fall;
         RX_DATA:   w_data_smp   = w_bit_done;
`ifdef UART_RX_PARITY_EN
         RX_PARITY: w_par_smp    = w_bit_done;
`endif
         RX_STOP:   w_stop_smp   = w_bit_done;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || r_state == RX_IDLE)
         r_tcnt <= '0;
      else if (w_tick)
         r_tcnt <= (w_half_done || w_bit_done) ? '0 : r_tcnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst || r_state == RX_IDLE || r_state == RX_START)
         r_bit_idx <= '0;
      else if (w_data_smp)
         r_bit_idx <= r_bit_idx + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_shift <= '0;
      else if (w_data_smp)
         r_shift <= {r_sync2, r_shift[UART_DATA_BITS-1:1]};
   end

`ifdef UART_RX_PARITY_EN
   logic r_par_err, r_parity_err;

   always_ff @(posedge clk) begin
      if (rst || r_state == RX_START)
         r_par_err <= 1'b0;
      else if (w_par_smp)
         r_par_err <= (r_sync2 != parity_bit(r_shift, PARITY_ODD));
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_parity_err <= 1'b0;
      else
         r_parity_err <= w_stop_smp & r_sync2 & r_par_err;
   end

   assign w_complete = w_stop_smp & r_sync2 & ~r_par_err;
   assign parity_err = r_parity_err;
`else
   logic w_unused_parity;
   assign w_unused_parity = PARITY_ODD;
   assign w_complete      = w_stop_smp & r_sync2;
   assign parity_err      = 1'b0;
`endif

   // A completing byte loads only if the output slot is free or being drained this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= w_stop_smp & ~r_sync2;
         r_overrun   <= w_complete & r_valid & ~rx_ready;
         if (w_complete && (!r_valid || rx_ready)) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end else if (r_valid && rx_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign rx_data    = r_data;
   assign rx_valid   = r_valid;
   assign frame_err  = r_frame_err;
   assign rx_overrun = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Scenario bench for uart_rx at DIV=10, 160 clk per bit; expected bytes are queued as frames are sent.
module tb_uart_rx;
   localparam int CLK_RATE   = 1_600_000;
   localparam int BAUD_RATE  = 10_000;
   localparam int OVERSAMPLE = 16;
   localparam int BIT_CLK    = 160;
`ifdef UART_RX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   // Start drive to rx_valid visible: 3 clk front end + 152 ticks of 10 clk, minus the 160 clk of stop bit already counted.
   localparam int VALID_LAT = (FRAME_BITS - 1) * BIT_CLK + 83;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_in = 1'b1;
   logic       rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, parity_err, rx_overrun;

   uart_rx #(
      .CLK_RATE   (CLK_RATE),
      .BAUD_RATE  (BAUD_RATE),
      .OVERSAMPLE (OVERSAMPLE),
      .PARITY_ODD (1'b0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_in      (rx_in),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .rx_overrun (rx_overrun)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int t0 = 0;

   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];
   int obs_rd = 0;

   int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, dbl_cnt = 0, vhigh_cnt = 0, vrise_cyc = 0;
   logic vld_d = 1'b0, fe_d = 1'b0, pe_d = 1'b0, ov_d = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rx_valid && rx_ready) obs_q.push_back(rx_data);
      if (rx_valid && !vld_d) vrise_cyc = cyc;
      if (rx_valid) vhigh_cnt++;
      if (frame_err) fe_cnt++;
      if (parity_err) pe_cnt++;
      if (rx_overrun) ov_cnt++;
      if ((frame_err && fe_d) || (parity_err && pe_d) || (rx_overrun && ov_d)) dbl_cnt++;
      vld_d = rx_valid;
      fe_d  = frame_err;
      pe_d  = parity_err;
      ov_d  = rx_overrun;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives one frame; the final (stop) bit is held for stop_len clocks and left on the line.
   task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop_val, input int stop_len);
      logic [10:0] f;
      logic pbit;
      pbit = (^d) ^ pflip;
`ifdef UART_RX_PARITY_EN
      f = {stop_val, pbit, d, 1'b0};
`else
      f = {pbit, stop_val, d, 1'b0};
`endif
      t0 = cyc;
      for (int i = 0; i < FRAME_BITS - 1; i++) begin
         rx_in = f[i];
         wait_clk(BIT_CLK);
      end
      rx_in = f[FRAME_BITS-1];
      wait_clk(stop_len);
   endtask

   task automatic test_reset;
      rst = 1'b1; rx_in = 1'b1; rx_ready = 1'b1;
      wait_clk(5);
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
      checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", rx_overrun); end
      rst = 1'b0;
      wait_clk(20);
   endtask

   task automatic test_basic;
      int fe0, pe0, ov0, vh0;
      logic [7:0] e;
      fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt; vh0 = vhigh_cnt;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b0, 1'b1, BIT_CLK);
      wait_clk(20);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_rd >= obs_q.size()) begin errors++; $display("FAIL basic_data: got none want %h", e); end
         else begin
            if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL basic_data: got %h want %h", obs_q[obs_rd], e); end
            obs_rd++;
         end
      end
      checks++; if (vhigh_cnt - vh0 != 1) begin errors++; $display("FAIL basic_valid_width: got %0d want 1", vhigh_cnt - vh0); end
      checks++; if (vrise_cyc - t0 < VALID_LAT - 2 || vrise_cyc - t0 > VALID_LAT + 2)
         begin errors++; $display("FAIL basic_latency: got %0d want %0d", vrise_cyc - t0, VALID_LAT); end
      checks++; if (fe_cnt != fe0 || pe_cnt != pe0 || ov_cnt != ov0)
         begin errors++; $display("FAIL basic_no_err: got fe=%0d pe=%0d ov=%0d want 0", fe_cnt-fe0, pe_cnt-pe0, ov_cnt-ov0); end
   endtask

   task automatic test_glitch;
      int fe0, pe0;
      logic [7:0] e;
      fe0 = fe_cnt; pe0 = pe_cnt;
      rx_in = 1'b0;
      wait_clk(40);
      rx_in = 1'b1;
      wait_clk(300);
      checks++; if (obs_q.size() != obs_rd || rx_valid !== 1'b0)
         begin errors++; $display("FAIL glitch_no_byte: got %0d bytes valid=%b want 0", obs_q.size() - obs_rd, rx_valid); end
      checks++; if (fe_cnt != fe0 || pe_cnt != pe0)
         begin errors++; $display("FAIL glitch_no_err: got fe=%0d pe=%0d want 0", fe_cnt-fe0, pe_cnt-pe0); end
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b0, 1'b1, BIT_CLK);
      wait_clk(20);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_rd >= obs_q.size()) begin errors++; $display("FAIL glitch_next_data: got none want %h", e); end
         else begin
            if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL glitch_next_data: got %h want %h", obs_q[obs_rd], e); end
            obs_rd++;
         end
      end
   endtask

   task automatic test_frame_err;
      int fe0, vh0, d0;
      fe0 = fe_cnt; vh0 = vhigh_cnt; d0 = dbl_cnt;
      send_frame(8'h55, 1'b0, 1'b0, BIT_CLK);
      wait_clk(1800);
      checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL frame_err_count: got %0d want 1", fe_cnt - fe0); end
      checks++; if (dbl_cnt != d0) begin errors++; $display("FAIL frame_err_width: got %0d long pulses want 0", dbl_cnt - d0); end
      checks++; if (vhigh_cnt != vh0 || obs_q.size() != obs_rd)
         begin errors++; $display("FAIL frame_err_no_valid: got %0d valid cycles want 0", vhigh_cnt - vh0); end
      rx_in = 1'b1;
      wait_clk(300);
      checks++; if (fe_cnt - fe0 != 1 || vhigh_cnt != vh0)
         begin errors++; $display("FAIL break_no_rearm: got fe=%0d valid_cycles=%0d want 1,0", fe_cnt - fe0, vhigh_cnt - vh0); end
   endtask

   task automatic test_overrun;
      int ov0, d0;
      logic [7:0] e;
      ov0 = ov_cnt; d0 = dbl_cnt;
      rx_ready = 1'b0;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b0, 1'b1, BIT_CLK);
      checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11)
         begin errors++; $display("FAIL ovr_first_hold: got valid=%b data=%h want 1,11", rx_valid, rx_data); end
      send_frame(8'h22, 1'b0, 1'b1, BIT_CLK);
      wait_clk(20);
      checks++; if (ov_cnt - ov0 != 1 || dbl_cnt != d0)
         begin errors++; $display("FAIL ovr_pulse: got %0d pulses want 1", ov_cnt - ov0); end
      checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11)
         begin errors++; $display("FAIL ovr_retain: got valid=%b data=%h want 1,11", rx_valid, rx_data); end
      rx_ready = 1'b1;
      @(negedge clk);
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_accept_cycle: got valid=%b want 1", rx_valid); end
      wait_clk(1);
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_fall: got valid=%b want 0", rx_valid); end
      wait_clk(5);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_rd >= obs_q.size()) begin errors++; $display("FAIL ovr_data: got none want %h", e); end
         else begin
            if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL ovr_data: got %h want %h", obs_q[obs_rd], e); end
            obs_rd++;
         end
      end
      checks++; if (obs_q.size() != obs_rd) begin errors++; $display("FAIL ovr_extra: got %0d extra bytes want 0", obs_q.size() - obs_rd); end
   endtask

   task automatic test_parity;
`ifdef UART_RX_PARITY_EN
      int pe0, vh0;
      logic [7:0] e;
      pe0 = pe_cnt;
      exp_q.push_back(8'h07);
      send_frame(8'h07, 1'b0, 1'b1, BIT_CLK);
      wait_clk(20);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_rd >= obs_q.size()) begin errors++; $display("FAIL par_good_data: got none want %h", e); end
         else begin
            if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL par_good_data: got %h want %h", obs_q[obs_rd], e); end
            obs_rd++;
         end
      end
      checks++; if (pe_cnt != pe0) begin errors++; $display("FAIL par_good_no_err: got %0d want 0", pe_cnt - pe0); end
      vh0 = vhigh_cnt;
      send_frame(8'h07, 1'b1, 1'b1, BIT_CLK);
      wait_clk(20);
      checks++; if (pe_cnt - pe0 != 1) begin errors++; $display("FAIL par_bad_pulse: got %0d want 1", pe_cnt - pe0); end
      checks++; if (vhigh_cnt != vh0 || obs_q.size() != obs_rd)
         begin errors++; $display("FAIL par_bad_no_valid: got %0d valid cycles want 0", vhigh_cnt - vh0); end
`else
      checks++; if (pe_cnt != 0) begin errors++; $display("FAIL par_tied_low: got %0d pulses want 0", pe_cnt); end
`endif
   endtask

   task automatic test_reset_midframe;
      int fe0, pe0, ov0;
      logic [7:0] e;
      fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
      rx_in = 1'b0; wait_clk(BIT_CLK);
      for (int i = 0; i < 4; i++) begin rx_in = 1'b0; wait_clk(BIT_CLK); end
      rx_in = 1'b1; wait_clk(80);
      rst = 1'b1; wait_clk(1); rst = 1'b0;
      checks++; if ({rx_valid, rx_data, frame_err, parity_err, rx_overrun} !== 12'h000)
         begin errors++; $display("FAIL rst_mid_outputs: got v=%b d=%h fe=%b pe=%b ov=%b want 0", rx_valid, rx_data, frame_err, parity_err, rx_overrun); end
      wait_clk(80 + (FRAME_BITS - 5) * BIT_CLK + 400);
      checks++; if (fe_cnt != fe0 || pe_cnt != pe0 || ov_cnt != ov0 || obs_q.size() != obs_rd)
         begin errors++; $display("FAIL rst_mid_quiet: got fe=%0d pe=%0d ov=%0d bytes=%0d want 0", fe_cnt-fe0, pe_cnt-pe0, ov_cnt-ov0, obs_q.size()-obs_rd); end
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b0, 1'b1, BIT_CLK);
      wait_clk(20);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_rd >= obs_q.size()) begin errors++; $display("FAIL rst_next_data: got none want %h", e); end
         else begin
            if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL rst_next_data: got %h want %h", obs_q[obs_rd], e); end
            obs_rd++;
         end
      end
   endtask

   task automatic test_back_to_back;
      int vh0;
      logic [7:0] e;
      vh0 = vhigh_cnt;
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'hC3);
      send_frame(8'h5A, 1'b0, 1'b1, 100);
      send_frame(8'hC3, 1'b0, 1'b1, BIT_CLK);
      wait_clk(20);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_rd >= obs_q.size()) begin errors++; $display("FAIL b2b_data: got none want %h", e); end
         else begin
            if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL b2b_data: got %h want %h", obs_q[obs_rd], e); end
            obs_rd++;
         end
      end
      checks++; if (vhigh_cnt - vh0 != 2) begin errors++; $display("FAIL b2b_valid_cycles: got %0d want 2", vhigh_cnt - vh0); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_parity();
      test_reset_midframe();
      test_back_to_back();
      checks++; if (dbl_cnt != 0) begin errors++; $display("FAIL pulse_width_total: got %0d long pulses want 0", dbl_cnt); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
